// File: rtl/fnn_sequencer.sv
// Control sequencer for the fully-connected network datapath: walks each sample
// through N_LAYERS layer steps plus a label check, counting addresses and correct predictions.
module fnn_sequencer #(
  parameter  int N_LAYERS  = 3,
  parameter  int NEURONS   = 10,
  parameter  int N_SAMPLES = 750,
  parameter  int ADDR_W    = 10,
  localparam int LW        = $clog2(N_LAYERS + 1)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start,
  input  logic                         mem_valid,
  input  logic                         eq,
  output logic                         busy,
  output logic                         done,
  output logic [ADDR_W-1:0]            addr,
  output logic [ADDR_W-1:0]            correct_cnt,
  output logic                         read_mem_inp,
  output logic                         read_mem_label,
  output logic                         sel_inp,
  output logic                         sel_reg,
  output logic [LW-1:0]                sel_w,
  output logic [LW-1:0]                sel_b,
  output logic [N_LAYERS*NEURONS-1:0]  ld_reg,
  output logic                         cnt_addr_en,
  output logic                         cnt_ac_en
);

  typedef enum logic [1:0] {S_IDLE, S_LAYER, S_CHECK, S_DONE} state_t;

  localparam logic [LW-1:0]     LAST_L = LW'(N_LAYERS - 1);
  localparam logic [ADDR_W-1:0] LAST_A = ADDR_W'(N_SAMPLES - 1);

  state_t              state, state_nxt;
  logic [LW-1:0]       l, l_nxt;
  logic [ADDR_W-1:0]   addr_nxt, cnt_nxt;
  logic                ld_en;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= S_IDLE;
      l           <= '0;
      addr        <= '0;
      correct_cnt <= '0;
    end else begin
      state       <= state_nxt;
      l           <= l_nxt;
      addr        <= addr_nxt;
      correct_cnt <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt      = state;
    l_nxt          = l;
    addr_nxt       = addr;
    cnt_nxt        = correct_cnt;
    busy           = 1'b0;
    done           = 1'b0;
    read_mem_inp   = 1'b0;
    read_mem_label = 1'b0;
    sel_inp        = 1'b0;
    sel_reg        = 1'b0;
    sel_w          = '0;
    sel_b          = '0;
    cnt_addr_en    = 1'b0;
    cnt_ac_en      = 1'b0;
    ld_en          = 1'b0;
    case (state)
      S_IDLE, S_DONE: begin
        done = (state == S_DONE);
        if (start) begin
          state_nxt = S_LAYER;
          l_nxt     = '0;
          addr_nxt  = '0;
          cnt_nxt   = '0;
        end
      end
      S_LAYER: begin
        busy         = 1'b1;
        read_mem_inp = 1'b1;
        sel_w        = l;
        sel_b        = l;
        sel_inp      = (l == '0);
        // only the first layer consumes memory data, so only it waits on mem_valid
        if (l != '0 || mem_valid) begin
          ld_en = 1'b1;
          if (l == LAST_L) state_nxt = S_CHECK;
          else             l_nxt     = l + 1'b1;
        end
      end
      S_CHECK: begin
        busy           = 1'b1;
        sel_reg        = 1'b1;
        sel_w          = LW'(N_LAYERS);
        sel_b          = LW'(N_LAYERS);
        read_mem_label = 1'b1;
        cnt_addr_en    = 1'b1;
        cnt_ac_en      = eq;
        if (eq) cnt_nxt = correct_cnt + 1'b1;
        if (addr == LAST_A) begin
          state_nxt = S_DONE;
        end else begin
          addr_nxt  = addr + 1'b1;
          l_nxt     = '0;
          state_nxt = S_LAYER;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  for (genvar g = 0; g < N_LAYERS; g++) begin : g_ld
    assign ld_reg[g*NEURONS +: NEURONS] = {NEURONS{ld_en && (l == LW'(g))}};
  end

endmodule
